fifo_pop_arbiter: RTL
=====================

FIFO_POP_ARBITER -- requirements
Module: fifo_pop_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_SIZE, default 10, width of each queue data word; NUM_Q, default 4, number of drained queues (fixed at 4; the queue id is 2 bits).
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 q_empty  in  NUM_Q  per-queue empty flag from each upstream FIFO.
REQ-005 q_data  in  NUM_Q*DATA_SIZE  registered pop data of each upstream FIFO; queue i occupies bits [i*DATA_SIZE +: DATA_SIZE].
REQ-006 ds_pause  in  1  downstream almost-full/pause.
REQ-007 ds_full  in  1  downstream full.
REQ-008 q_pop  out  NUM_Q  registered one-hot pop strobe to the upstream FIFOs.
REQ-009 push_out  out  1  registered push strobe to the downstream FIFO.
REQ-010 data_out  out  DATA_SIZE  registered word delivered with push_out.
REQ-011 q_id  out  2  registered source-queue id of data_out.
REQ-012 overflow_err  out  1  sticky error: a push occurred while ds_full was high.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, POP and DRAIN, with the encodings held in the shared package.
REQ-015 IDLE -> POP when ds_pause=0 and any q_empty bit is 0.
REQ-016 POP -> DRAIN when ds_pause=1.
REQ-017 POP -> IDLE when all queues are empty and no pop is in flight.
REQ-018 DRAIN -> POP when ds_pause=0 and any queue is non-empty.
REQ-019 DRAIN -> IDLE when ds_pause=0, all queues are empty and nothing is in flight.
REQ-020 At most one q_pop bit SHALL be high per cycle, and only in state POP while ds_pause=0.
REQ-021 q_pop[i] SHALL never assert while q_empty[i]=1 in the same cycle.
REQ-022 Grant SHALL be round-robin: the search starts at last_grant+1 modulo 4, and the first non-empty queue wins.
REQ-023 last_grant SHALL update only on an issued pop; its reset value is 3, so queue 0 has first priority.
REQ-024 Latency: q_pop in cycle N makes q_data valid in N+1; push_out, data_out and q_id SHALL be valid in cycle N+2.
REQ-025 The block SHALL use a 2-stage in-flight pipeline (valid bit plus id per stage); maximum in flight is 2.
REQ-026 Back-to-back pops SHALL give one push per cycle: 100% throughput while ds_pause=0.
REQ-027 Assertion of ds_pause SHALL stop new pops from the next cycle.
REQ-028 Words already in flight SHALL still be pushed, at most 2, within the slack of a downstream almost-full threshold of 6 of 8.
REQ-029 A push in a cycle with ds_full=1 SHALL still occur and SHALL set overflow_err; the word is not retried.
REQ-030 overflow_err SHALL clear only on reset.
REQ-031 A queue that goes empty mid-burst SHALL be skipped on the next arbitration with no bubble, provided another queue is non-empty.
REQ-032 If all queues are empty, the block SHALL issue no pop; push_out stays 0 after the pipeline drains.
REQ-033 The pointer SHALL wrap from 3 to 0 with no idle cycle.

Reset
REQ-034 While reset=0 at a clock edge, the block SHALL set state=IDLE, q_pop=0, push_out=0, data_out=0, q_id=0, overflow_err=0, last_grant=3, and pipeline valids=0.
REQ-035 A reset asserted mid-operation SHALL discard in-flight words with no push; no output SHALL be high in the cycle after the reset edge.

Structure
REQ-036 The shared package SHALL hold DATA_SIZE, NUM_Q, the state encodings and the pipeline depth constant (2).
REQ-037 The round-robin grant logic SHALL be a sub-module rr_arbiter_4, combinational: inputs req[3:0] and last_grant[1:0]; outputs gnt[3:0] and gnt_id[1:0].
REQ-038 Implementation size SHALL be about 200-300 lines including rr_arbiter_4.

Verification
REQ-039 Bench SHALL load queue 0 with 0x001 and 0x002 and queue 2 with 0x201, ds_pause=0 -> pops Q0, Q2, Q0 in consecutive cycles; pushes 0x001 (id 0), 0x201 (id 2), 0x002 (id 0) in cycles 2, 3 and 4 after the first pop.
REQ-040 Bench SHALL raise ds_pause one cycle after the first pop with all queues holding 3 words -> exactly 2 pushes follow, then push_out=0 and state DRAIN; dropping ds_pause resumes with the next round-robin queue.
REQ-041 Bench SHALL hold all queues empty for 10 cycles -> q_pop=0, push_out=0, busy=0 throughout.
REQ-042 Bench SHALL force ds_full=1 during a push of 0x3FF -> 0x3FF is pushed and overflow_err=1, which persists until reset.
REQ-043 Bench SHALL assert reset with 2 words in flight -> no push in the following cycles, all outputs 0, and queue 0 is granted first after reset is released.
REQ-044 Bench SHALL make all 4 queues non-empty for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one push per cycle.

Source files
------------

// File: rtl/fifo_pop_arbiter_pkg.sv
// Shared constants and state encoding for the FIFO pop arbiter and its grant logic.
package fifo_pop_arbiter_pkg;

    localparam int DATA_SIZE  = 10;
    localparam int NUM_Q      = 4;
    localparam int PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_pop_arbiter_rr_arbiter_4.sv
// Combinational four-way round-robin grant: the search starts one past the last granted
// queue and the first requesting queue wins.
module rr_arbiter_4
    import fifo_pop_arbiter_pkg::*;
(
    input  logic [NUM_Q-1:0] req,
    input  logic [1:0]       last_grant,
    output logic [NUM_Q-1:0] gnt,
    output logic [1:0]       gnt_id
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            w_idx = last_grant + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Drains four upstream FIFOs round-robin into one downstream FIFO through a two-stage
// in-flight pipeline (pop -> data valid -> push), honouring downstream pause.
module fifo_pop_arbiter #(
    parameter int DATA_SIZE = fifo_pop_arbiter_pkg::DATA_SIZE,
    parameter int NUM_Q     = fifo_pop_arbiter_pkg::NUM_Q
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_Q-1:0]           q_empty,
    input  logic [NUM_Q*DATA_SIZE-1:0] q_data,
    input  logic                       ds_pause,
    input  logic                       ds_full,
    output logic [NUM_Q-1:0]           q_pop,
    output logic                       push_out,
    output logic [DATA_SIZE-1:0]       data_out,
    output logic [1:0]                 q_id,
    output logic                       overflow_err,
    output logic                       busy
);
    import fifo_pop_arbiter_pkg::*;

    state_t                      r_state;
    logic [NUM_Q-1:0]            r_qPop;
    logic [1:0]                  r_lastGrant;
    logic [PIPE_DEPTH-1:0]       r_pipeValid;
    logic [PIPE_DEPTH-1:0][1:0]  r_pipeId;
    logic                        r_push;
    logic [DATA_SIZE-1:0]        r_data;
    logic [1:0]                  r_qId;
    logic                        r_overflow;

    logic [NUM_Q-1:0]            w_req;
    logic [NUM_Q-1:0]            w_gnt;
    logic [1:0]                  w_gntId;
    logic                        w_anyReq;
    logic                        w_issue;
    logic                        w_inFlight;
    logic [DATA_SIZE-1:0]        w_popData;

    // A queue being popped this cycle still shows its pre-pop empty flag, so it sits out
    // one arbitration rather than risk popping an already-empty FIFO.
    assign w_req      = ~q_empty & ~r_qPop;
    assign w_anyReq   = |w_req;
    assign w_issue    = !ds_pause && w_anyReq;
    assign w_inFlight = |r_pipeValid;
    assign w_popData  = q_data[int'(r_pipeId[PIPE_DEPTH-1]) * DATA_SIZE +: DATA_SIZE];

    rr_arbiter_4 u_rrArbiter (
        .req        (w_req),
        .last_grant (r_lastGrant),
        .gnt        (w_gnt),
        .gnt_id     (w_gntId)
    );

    // Every issued pop moves the FSM to POP, so a pop strobe is only ever seen in POP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_qPop      <= '0;
            r_lastGrant <= 2'd3;
            r_pipeValid <= '0;
            r_pipeId    <= '0;
            r_push      <= 1'b0;
            r_data      <= '0;
            r_qId       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_qPop      <= w_issue ? w_gnt : '0;
            r_pipeValid <= {r_pipeValid[PIPE_DEPTH-2:0], w_issue};
            r_pipeId    <= {r_pipeId[PIPE_DEPTH-2:0], w_gntId};
            r_push      <= r_pipeValid[PIPE_DEPTH-1];
            if (w_issue) begin
                r_lastGrant <= w_gntId;
            end
            if (r_pipeValid[PIPE_DEPTH-1]) begin
                r_data <= w_popData;
                r_qId  <= r_pipeId[PIPE_DEPTH-1];
            end
            if (r_push && ds_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (ds_pause) begin
                        r_state <= ST_DRAIN;
                    end else if (!w_anyReq && !w_inFlight) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_issue) begin
                        r_state <= ST_POP;
                    end else if (!ds_pause && !w_inFlight) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign q_pop        = r_qPop;
    assign push_out     = r_push;
    assign data_out     = r_data;
    assign q_id         = r_qId;
    assign overflow_err = r_overflow;
    assign busy         = (r_state != ST_IDLE);

endmodule
